// File: rtl/bcd_demux_pkg.sv
// Shared types and helpers for the multiplexed BCD display bus receiver.
package bcd_demux_pkg;

   typedef enum logic [1:0] {
      SEL_BLANK   = 2'd0,
      SEL_VALID   = 2'd1,
      SEL_INVALID = 2'd2
   } sel_class_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic int clogb2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Select is passed zero-extended; buses wider than 32 positions are not supported.
   function automatic sel_class_e sel_class(input logic [31:0] sel);
      int n;
      n = $countones(sel);
      if (n == 0)      return SEL_BLANK;
      else if (n == 1) return SEL_VALID;
      else             return SEL_INVALID;
   endfunction

endpackage

// File: rtl/bcd_demux_if.sv
// Scan-bus side (muxed nibble + one-hot select) and reconstructed-word side of the receiver.
interface bcd_demux_if #(
   parameter int DISPLAYS_NUM = 4
);
   logic [3:0]                  i_bcd_muxed;
   logic [DISPLAYS_NUM-1:0]     i_bcd_sel;
   logic                        i_err_clr;
   logic [4*DISPLAYS_NUM-1:0]   o_bcd_data;
   logic                        o_frame_valid;
   logic                        o_sel_err;
   logic                        o_bcd_err;

   modport master (
      output i_bcd_muxed, i_bcd_sel, i_err_clr,
      input  o_bcd_data, o_frame_valid, o_sel_err, o_bcd_err
   );

   modport slave (
      input  i_bcd_muxed, i_bcd_sel, i_err_clr,
      output o_bcd_data, o_frame_valid, o_sel_err, o_bcd_err
   );
endinterface

// File: rtl/bcd_demux_settle.sv
// Dwell tracker: classifies the select each edge and strobes a capture once a
// valid select has been stable for SETTLE_CYCLES consecutive edges.
module bcd_demux_settle
   import bcd_demux_pkg::*;
#(
   parameter int  DISPLAYS_NUM  = 4,
   parameter int  SETTLE_CYCLES = 3,
   localparam int IDX_W = (clogb2(DISPLAYS_NUM) < 1) ? 1 : clogb2(DISPLAYS_NUM)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [3:0]              bcd_muxed,
   input  logic [DISPLAYS_NUM-1:0] bcd_sel,
   output logic                    cap,
   output logic [IDX_W-1:0]        cap_idx,
   output logic [3:0]              cap_nib,
   output logic                    sel_inv
);

   localparam int             CNT_W   = (clogb2(SETTLE_CYCLES) < 1) ? 1 : clogb2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

   logic [DISPLAYS_NUM-1:0] sel_q;
   logic [CNT_W-1:0]        cnt_q, cnt_nxt;
   logic                    capd_q, capd_nxt;
   sel_class_e              cls;
   logic                    same;

   assign cls     = sel_class(32'(bcd_sel));
   assign same    = (bcd_sel == sel_q);
   assign sel_inv = (cls == SEL_INVALID);
   assign cap_nib = bcd_muxed;

   // A new dwell starts at count 0 with the captured flag cleared, so the
   // same "count reached max and not yet captured" test covers SETTLE_CYCLES=1.
   always_comb begin
      cnt_nxt  = '0;
      capd_nxt = 1'b0;
      cap      = 1'b0;
      if (cls == SEL_VALID) begin
         if (same) begin
            cnt_nxt  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            capd_nxt = capd_q;
         end
         cap      = (cnt_nxt == CNT_MAX) && !capd_nxt;
         capd_nxt = capd_nxt | cap;
      end
   end

   always_comb begin
      cap_idx = '0;
      for (int k = 0; k < DISPLAYS_NUM; k++)
         if (bcd_sel[k]) cap_idx = IDX_W'(k);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sel_q  <= '0;
         cnt_q  <= '0;
         capd_q <= 1'b0;
      end else begin
         sel_q  <= bcd_sel;
         cnt_q  <= cnt_nxt;
         capd_q <= capd_nxt;
      end
   end

endmodule

// File: rtl/bcd_demux.sv
// Scan-bus receiver: assembles settled digits into a shadow word and publishes
// complete frames to the parallel output, with sticky protocol error flags.
module bcd_demux
   import bcd_demux_pkg::*;
#(
   parameter int  DISPLAYS_NUM  = 4,
   parameter int  SETTLE_CYCLES = 3,
   localparam int IDX_W = (clogb2(DISPLAYS_NUM) < 1) ? 1 : clogb2(DISPLAYS_NUM)
) (
   input  logic        i_clk,
   input  logic        i_rst,
   bcd_demux_if.slave  bus
);

   logic                         cap, sel_inv;
   logic [IDX_W-1:0]             cap_idx, cap_pos;
   logic [3:0]                   cap_nib;
   logic [DISPLAYS_NUM-1:0][3:0] shadow_q, data_q;
   logic [DISPLAYS_NUM-1:0]      seen_q, seen_nxt;
   logic                         pend_q, fv_q, sel_err_q, bcd_err_q;

   bcd_demux_settle #(
      .DISPLAYS_NUM  (DISPLAYS_NUM),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .bcd_muxed (bus.i_bcd_muxed),
      .bcd_sel   (bus.i_bcd_sel),
      .cap       (cap),
      .cap_idx   (cap_idx),
      .cap_nib   (cap_nib),
      .sel_inv   (sel_inv)
   );

   // Select bit 0 is the most significant digit, i.e. the top packed element.
   assign cap_pos = IDX_W'(DISPLAYS_NUM - 1) - cap_idx;

   // The mask is cleared on the publish edge; a capture on that same edge starts the next frame.
   always_comb begin
      seen_nxt = pend_q ? '0 : seen_q;
      if (cap) seen_nxt[cap_idx] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shadow_q  <= '0;
         data_q    <= '0;
         seen_q    <= '0;
         pend_q    <= 1'b0;
         fv_q      <= 1'b0;
         sel_err_q <= 1'b0;
         bcd_err_q <= 1'b0;
      end else begin
         if (cap) shadow_q[cap_pos] <= cap_nib;
         if (pend_q) data_q <= shadow_q;
         fv_q   <= pend_q;
         seen_q <= seen_nxt;
         pend_q <= cap && (&seen_nxt);
         if (sel_inv)                     sel_err_q <= 1'b1;
         else if (bus.i_err_clr)          sel_err_q <= 1'b0;
         if (cap && (cap_nib > BCD_MAX))  bcd_err_q <= 1'b1;
         else if (bus.i_err_clr)          bcd_err_q <= 1'b0;
      end
   end

   assign bus.o_bcd_data    = data_q;
   assign bus.o_frame_valid = fv_q;
   assign bus.o_sel_err     = sel_err_q;
   assign bus.o_bcd_err     = bcd_err_q;

endmodule

// File: tb/tb_bcd_demux.sv
// Randomised and directed bench for bcd_demux against a run-length reference model.
module tb_bcd_demux;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   always #5 i_clk = ~i_clk;

   bcd_demux_if #(.DISPLAYS_NUM(4)) bus1();
   bcd_demux_if #(.DISPLAYS_NUM(2)) bus2();

   bcd_demux #(.DISPLAYS_NUM(4), .SETTLE_CYCLES(3)) u_dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus1)
   );

   bcd_demux #(.DISPLAYS_NUM(2), .SETTLE_CYCLES(1)) u_dut2 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus2)
   );

   int n_chk = 0;
   int n_err = 0;
   int act, mN, mS;
   int cyc, fv_cnt, fv_cyc;

   // reference model state
   int          run;
   logic [31:0] prev_sel;
   logic [3:0]  shadow_m [4];
   bit          seen_m   [4];
   bit          pend;
   logic [31:0] pend_data, exp_data;
   bit          exp_fv, exp_se, exp_be;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      run = 0; prev_sel = '0; pend = 0; pend_data = '0; exp_data = '0;
      exp_fv = 0; exp_se = 0; exp_be = 0;
      for (int k = 0; k < 4; k++) begin shadow_m[k] = '0; seen_m[k] = 0; end
   endtask

   // One clock edge: a digit is taken when a one-hot select has been held for exactly mS edges.
   task automatic model_edge(input logic [3:0] sel, input logic [3:0] nib, input logic clr);
      int ones, pos;
      bit cap, all;
      logic [31:0] d;
      ones   = $countones(sel);
      exp_fv = pend;
      if (pend) exp_data = pend_data;
      pend = 0;
      if (ones == 1) run = (32'(sel) == prev_sel) ? run + 1 : 1;
      else           run = 0;
      prev_sel = 32'(sel);
      cap = (ones == 1) && (run == mS);
      if (clr) begin exp_se = 0; exp_be = 0; end
      if (ones > 1) exp_se = 1;
      if (cap && nib > 4'd9) exp_be = 1;
      if (cap) begin
         pos = 0;
         for (int k = 0; k < mN; k++) if (sel[k]) pos = k;
         shadow_m[pos] = nib;
         seen_m[pos]   = 1;
         all = 1;
         for (int k = 0; k < mN; k++) if (!seen_m[k]) all = 0;
         if (all) begin
            d = '0;
            for (int k = 0; k < mN; k++) d = d | (32'(shadow_m[k]) << (4 * (mN - 1 - k)));
            pend = 1; pend_data = d;
            for (int k = 0; k < 4; k++) seen_m[k] = 0;
         end
      end
   endtask

   task automatic step(input logic [3:0] sel, input logic [3:0] nib, input logic clr);
      logic [31:0] od;
      logic ofv, ose, obe;
      if (act == 0) begin
         bus1.i_bcd_sel = sel; bus1.i_bcd_muxed = nib; bus1.i_err_clr = clr;
      end else begin
         bus2.i_bcd_sel = sel[1:0]; bus2.i_bcd_muxed = nib; bus2.i_err_clr = clr;
      end
      @(posedge i_clk);
      model_edge(sel, nib, clr);
      cyc++;
      #1;
      if (act == 0) begin
         od = 32'(bus1.o_bcd_data); ofv = bus1.o_frame_valid; ose = bus1.o_sel_err; obe = bus1.o_bcd_err;
      end else begin
         od = 32'(bus2.o_bcd_data); ofv = bus2.o_frame_valid; ose = bus2.o_sel_err; obe = bus2.o_bcd_err;
      end
      chk("data", od, exp_data);
      chk("frame_valid", 32'(ofv), 32'(exp_fv));
      chk("sel_err", 32'(ose), 32'(exp_se));
      chk("bcd_err", 32'(obe), 32'(exp_be));
      if (ofv) begin fv_cnt++; fv_cyc = cyc; end
   endtask

   task automatic seg(input logic [3:0] sel, input logic [3:0] nib, input int len);
      repeat (len) step(sel, nib, 1'b0);
   endtask

   task automatic do_reset();
      i_rst = 1'b0;
      bus1.i_bcd_sel = '0; bus1.i_bcd_muxed = '0; bus1.i_err_clr = 1'b0;
      bus2.i_bcd_sel = '0; bus2.i_bcd_muxed = '0; bus2.i_err_clr = 1'b0;
      #3;
      chk("rst_data1", 32'(bus1.o_bcd_data), 32'h0);
      chk("rst_fv1",   32'(bus1.o_frame_valid), 32'h0);
      chk("rst_err1",  32'({bus1.o_sel_err, bus1.o_bcd_err}), 32'h0);
      chk("rst_data2", 32'(bus2.o_bcd_data), 32'h0);
      chk("rst_err2",  32'({bus2.o_frame_valid, bus2.o_sel_err, bus2.o_bcd_err}), 32'h0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      model_reset();
   endtask

   function automatic logic [3:0] rnd_nib();
      return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
   endfunction

   task automatic rand_segs(input int n);
      logic [3:0] sel, nib;
      int r, a, b, len;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) sel = '0;
         else if (r == 1) begin
            a = $urandom_range(0, mN - 1);
            b = (a + 1 + $urandom_range(0, mN - 2)) % mN;
            sel = 4'((1 << a) | (1 << b));
         end else sel = 4'(1 << $urandom_range(0, mN - 1));
         nib = rnd_nib();
         len = $urandom_range(1, 5);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) nib = rnd_nib();
            step(sel, nib, $urandom_range(0, 15) == 0);
         end
      end
   endtask

   initial begin
      logic [15:0] d16;
      act = 0; mN = 4; mS = 3;
      cyc = 0; fv_cnt = 0; fv_cyc = 0;
      model_reset();
      do_reset();

      // basic frame 1234
      cyc = 0; fv_cnt = 0;
      seg(4'b0001, 4'd1, 10); seg(4'b0010, 4'd2, 10);
      seg(4'b0100, 4'd3, 10); seg(4'b1000, 4'd4, 10);
      chk("f1_data", 32'(bus1.o_bcd_data), 32'h1234);
      chk("f1_fv_cyc", 32'(fv_cyc), 32'd34);
      chk("f1_fv_cnt", 32'(fv_cnt), 32'd1);
      chk("f1_errs", 32'({bus1.o_sel_err, bus1.o_bcd_err}), 32'h0);

      // short dwell must not capture
      seg(4'b0001, 4'd7, 2); seg(4'b0000, 4'd0, 1); seg(4'b0001, 4'd5, 10);
      seg(4'b0010, 4'd6, 4); seg(4'b0100, 4'd7, 4); seg(4'b1000, 4'd8, 4);
      seg(4'b0000, 4'd0, 2);
      chk("glitch_data", 32'(bus1.o_bcd_data), 32'h5678);

      // multi-hot select mid-frame
      seg(4'b0001, 4'd1, 4); seg(4'b0010, 4'd2, 4); seg(4'b0110, 4'd0, 1);
      chk("mh_set", 32'(bus1.o_sel_err), 32'd1);
      seg(4'b0000, 4'd0, 2);
      chk("mh_hold", 32'(bus1.o_sel_err), 32'd1);
      step(4'b0000, 4'd0, 1'b1);
      chk("mh_clr", 32'(bus1.o_sel_err), 32'd0);
      seg(4'b0100, 4'd3, 4); seg(4'b1000, 4'd4, 4); seg(4'b0000, 4'd0, 2);
      chk("mh_data", 32'(bus1.o_bcd_data), 32'h1234);

      // non-BCD nibble
      seg(4'b0001, 4'd1, 4); seg(4'b0010, 4'd2, 4);
      seg(4'b0100, 4'hC, 4); seg(4'b1000, 4'd4, 4); seg(4'b0000, 4'd0, 2);
      d16 = bus1.o_bcd_data;
      chk("nb_err", 32'(bus1.o_bcd_err), 32'd1);
      chk("nb_nib", 32'(d16[7:4]), 32'hC);
      step(4'b0000, 4'd0, 1'b1);
      chk("nb_clr", 32'(bus1.o_bcd_err), 32'd0);

      // reset mid-frame discards partial captures
      seg(4'b0001, 4'd9, 4); seg(4'b0010, 4'd8, 4); seg(4'b0100, 4'd7, 4);
      do_reset();
      fv_cnt = 0;
      seg(4'b0001, 4'd9, 4); seg(4'b0010, 4'd8, 4);
      seg(4'b0100, 4'd7, 4); seg(4'b1000, 4'd6, 4); seg(4'b0000, 4'd0, 3);
      chk("rst_frame_data", 32'(bus1.o_bcd_data), 32'h9876);
      chk("rst_frame_cnt", 32'(fv_cnt), 32'd1);

      rand_segs(250);

      // two positions, single-edge settle
      act = 1; mN = 2; mS = 1;
      do_reset();
      cyc = 0; fv_cnt = 0;
      seg(2'b01, 4'd8, 1); seg(2'b10, 4'd9, 1); seg(2'b00, 4'd0, 2);
      chk("s1_data", 32'(bus2.o_bcd_data), 32'h89);
      chk("s1_fv_cyc", 32'(fv_cyc), 32'd3);
      chk("s1_fv_cnt", 32'(fv_cnt), 32'd1);

      rand_segs(200);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
